// File: rtl/proc_clk_ctrl.sv
// rtl/proc_clk_ctrl.sv - free-run / debounced single-step clock enable for procesadorArm
// Optional CYCLE_COUNT_EN adds a 32-bit enabled-cycle counter port.
module proc_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_BURST      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_step,
  input  logic        clk_select,
  output logic        cpu_ce,
  output logic        step_busy,
  output logic        mode_step
`ifdef CYCLE_COUNT_EN
  ,
  output logic [31:0] cycle_count
`endif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(STEP_BURST + 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [BW-1:0] BURST_MAX = BW'(STEP_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE_P,
    PULSE,
    WAIT_REL
  } state_t;

  state_t        state, state_nx;
  logic          step_s1, step_s2;
  logic          sel_s1, sel_s2;
  logic [DW-1:0] deb_cnt, deb_nx, deb_inc;
  logic [BW-1:0] burst_cnt, burst_nx, burst_inc;
  logic          ce_nx;
  logic          busy_nx;

  assign deb_inc   = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + DEB_ONE;
  assign burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BURST_ONE;

  // sel_s2 is the value mode_step takes at this edge, so cpu_ce follows mode changes on the same edge
  always_comb begin
    state_nx = state;
    deb_nx   = deb_cnt;
    burst_nx = burst_cnt;
    ce_nx    = 1'b0;
    if (!sel_s2) begin
      state_nx = IDLE;
      deb_nx   = '0;
      burst_nx = '0;
      ce_nx    = 1'b1;
    end else if (!mode_step) begin
      // entering step mode: a button held through the switch must be released first
      state_nx = WAIT_REL;
      deb_nx   = '0;
      burst_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (step_s2) begin
            state_nx = DEBOUNCE_P;
            deb_nx   = DEB_ONE;
          end
        end
        DEBOUNCE_P: begin
          if (deb_cnt == DEB_MAX) begin
            state_nx = PULSE;
            deb_nx   = '0;
            burst_nx = '0;
            ce_nx    = 1'b1;
          end else if (!step_s2) begin
            state_nx = IDLE;
            deb_nx   = '0;
          end else begin
            deb_nx = deb_inc;
          end
        end
        PULSE: begin
          burst_nx = burst_inc;
          if (burst_inc == BURST_MAX) begin
            state_nx = WAIT_REL;
            deb_nx   = '0;
          end else begin
            ce_nx = 1'b1;
          end
        end
        WAIT_REL: begin
          if (step_s2) begin
            deb_nx = '0;
          end else if (deb_inc == DEB_MAX) begin
            state_nx = IDLE;
            deb_nx   = '0;
          end else begin
            deb_nx = deb_inc;
          end
        end
        default: begin
          state_nx = IDLE;
          deb_nx   = '0;
          burst_nx = '0;
        end
      endcase
    end
    busy_nx = sel_s2 & (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      sel_s1    <= 1'b0;
      sel_s2    <= 1'b0;
      mode_step <= 1'b0;
      state     <= IDLE;
      deb_cnt   <= '0;
      burst_cnt <= '0;
      cpu_ce    <= 1'b0;
      step_busy <= 1'b0;
    end else begin
      step_s1   <= clk_step;
      step_s2   <= step_s1;
      sel_s1    <= clk_select;
      sel_s2    <= sel_s1;
      mode_step <= sel_s2;
      state     <= state_nx;
      deb_cnt   <= deb_nx;
      burst_cnt <= burst_nx;
      cpu_ce    <= ce_nx;
      step_busy <= busy_nx;
    end
  end

`ifdef CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + {31'd0, cpu_ce};
    end
  end
`endif

endmodule

// File: tb/tb_proc_clk_ctrl.sv
// tb/tb_proc_clk_ctrl.sv - self-checking bench for proc_clk_ctrl (burst 3 and burst 8 instances)
module tb_proc_clk_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_step = 1'b0;
  logic        clk_select = 1'b0;
  logic [1:0]  ce_o, busy_o, mode_o;
  logic [31:0] cnt_o [2];

  int n_cmp = 0;
  int n_err = 0;
  int hi [2];
  int burst_len [2] = '{3, 8};

  always #5 clk = ~clk;

  proc_clk_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_BURST(3)) u_dut0 (
    .clk(clk), .rst(rst), .clk_step(clk_step), .clk_select(clk_select),
    .cpu_ce(ce_o[0]), .step_busy(busy_o[0]), .mode_step(mode_o[0])
`ifdef CYCLE_COUNT_EN
    , .cycle_count(cnt_o[0])
`endif
  );

  proc_clk_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_BURST(8)) u_dut1 (
    .clk(clk), .rst(rst), .clk_step(clk_step), .clk_select(clk_select),
    .cpu_ce(ce_o[1]), .step_busy(busy_o[1]), .mode_step(mode_o[1])
`ifdef CYCLE_COUNT_EN
    , .cycle_count(cnt_o[1])
`endif
  );

  // Reference model: raw inputs reach the decision logic two edges late; mode changes
  // take effect on the edge the synced select is registered. Each unit is either
  // armed (counting a stable press), emitting a burst, or waiting for a stable release.
  bit          m_s1, m_s2, m_c1, m_c2, m_mode;
  bit          m_ce [2];
  bit          m_armed [2];
  int          m_run1 [2], m_run0 [2], m_left [2];
  logic [31:0] m_cnt [2];

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_c1 = 0; m_c2 = 0; m_mode = 0;
    for (int i = 0; i < 2; i++) begin
      m_ce[i] = 0; m_armed[i] = 1; m_run1[i] = 0; m_run0[i] = 0; m_left[i] = 0;
      m_cnt[i] = 32'd0;
    end
  endfunction

  function automatic void model_edge(bit step, bit sel);
    bit s, mn, nce;
    s  = m_s2;
    mn = m_c2;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = m_cnt[i] + {31'd0, m_ce[i]};
      if (!mn) begin
        nce = 1; m_armed[i] = 1; m_run1[i] = 0; m_run0[i] = 0; m_left[i] = 0;
      end else if (!m_mode) begin
        nce = 0; m_armed[i] = 0; m_run1[i] = 0; m_run0[i] = 0; m_left[i] = 0;
      end else if (m_left[i] > 0) begin
        nce = (m_left[i] > 1);
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_armed[i] = 0; m_run0[i] = 0;
        end
      end else if (!m_armed[i]) begin
        nce = 0;
        m_run0[i] = s ? 0 : m_run0[i] + 1;
        if (m_run0[i] == D) begin
          m_armed[i] = 1; m_run1[i] = 0;
        end
      end else if (m_run1[i] >= D) begin
        nce = 1; m_left[i] = burst_len[i]; m_run1[i] = 0;
      end else begin
        nce = 0;
        m_run1[i] = s ? m_run1[i] + 1 : 0;
      end
      m_ce[i] = nce;
    end
    m_mode = mn;
    m_s2 = m_s1; m_s1 = step;
    m_c2 = m_c1; m_c1 = sel;
  endfunction

  function automatic bit model_busy(int i);
    return m_mode && (m_left[i] > 0 || !m_armed[i] || m_run1[i] > 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // starts and ends at a falling edge
  task automatic tick(bit step, bit sel);
    clk_step   = step;
    clk_select = sel;
    @(posedge clk);
    model_edge(step, sel);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_cpu_ce[%0d]", i), ce_o[i], m_ce[i]);
      chk($sformatf("model_step_busy[%0d]", i), busy_o[i], model_busy(i));
      chk($sformatf("model_mode_step[%0d]", i), mode_o[i], m_mode);
`ifdef CYCLE_COUNT_EN
      chk($sformatf("model_cycle_count[%0d]", i), cnt_o[i], m_cnt[i]);
`endif
      if (ce_o[i]) hi[i]++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit step;
    bit sel;
    bit ce;
    bit busy;
    bit mode;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int first, last, found, lows;
    bit sel_r;

    tbl = '{
      '{0, 0, 1, 0, 0}, '{0, 1, 1, 0, 0}, '{0, 1, 1, 0, 0}, '{0, 1, 0, 1, 1},
      '{0, 1, 0, 1, 1}, '{0, 1, 0, 1, 1}, '{0, 1, 0, 1, 1}, '{0, 1, 0, 0, 1},
      '{0, 0, 0, 0, 1}, '{0, 0, 0, 0, 1}, '{0, 0, 1, 0, 0}
    };

    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_cpu_ce", ce_o[i], 0);
      chk("reset_step_busy", busy_o[i], 0);
      chk("reset_mode_step", mode_o[i], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // free-run after reset, then a round trip through step mode
    for (int r = 0; r < 11; r++) begin
      tick(tbl[r].step, tbl[r].sel);
      chk($sformatf("tbl%0d_cpu_ce", r), ce_o[0], tbl[r].ce);
      chk($sformatf("tbl%0d_step_busy", r), busy_o[0], tbl[r].busy);
      chk($sformatf("tbl%0d_mode_step", r), mode_o[0], tbl[r].mode);
    end

    // clean press held for 40 cycles
    repeat (10) tick(0, 1);
    hi = '{0, 0}; first = -1; last = -1;
    for (int k = 0; k < 40; k++) begin
      tick(1, 1);
      if (ce_o[0]) begin
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("press_latency", first, D + 2);
    chk("burst3_last", last, D + 2 + 2);
    chk("burst3_len", hi[0], 3);
    chk("burst8_len", hi[1], 8);
    repeat (8) tick(0, 1);
    chk("release_busy0", busy_o[0], 0);
    chk("release_busy1", busy_o[1], 0);

    // bounce rejection
    hi = '{0, 0};
    tick(1, 1); tick(1, 1); tick(0, 1); tick(1, 1);
    tick(1, 1); tick(0, 1); tick(1, 1); tick(0, 1);
    repeat (8) tick(0, 1);
    chk("bounce_pulses0", hi[0], 0);
    chk("bounce_pulses1", hi[1], 0);
    chk("bounce_busy0", busy_o[0], 0);

    // button held while switching from free-run into step mode
    repeat (4) tick(1, 0);
    repeat (3) tick(1, 1);
    hi = '{0, 0};
    repeat (20) tick(1, 1);
    chk("held_switch_pulses", hi[0], 0);
    repeat (8) tick(0, 1);
    hi = '{0, 0};
    repeat (20) tick(1, 1);
    chk("held_new_press_burst", hi[0], 3);
    repeat (8) tick(0, 1);

    // abort an 8-cycle burst after two enabled cycles
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1, 1);
      if (ce_o[1]) begin
        found = 1;
        break;
      end
    end
    chk("abort_burst_started", found, 1);
    tick(1, 1);
    lows = 0;
    repeat (10) begin
      tick(1, 0);
      if (!ce_o[1]) lows++;
    end
    chk("abort_ce_gaps", lows, 0);
    chk("abort_busy", busy_o[1], 0);
    repeat (4) tick(0, 0);
    repeat (3) tick(0, 1);
    hi = '{0, 0};
    repeat (12) tick(0, 1);
    chk("abort_leftover", hi[1], 0);

    // reset in the middle of a burst
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1, 1);
      if (ce_o[1]) begin
        found = 1;
        break;
      end
    end
    chk("rst_burst_started", found, 1);
    rst = 1'b0;
    clk_step = 1'b0;
    #1;
    chk("rst_async_ce1", ce_o[1], 0);
    chk("rst_async_busy1", busy_o[1], 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) tick(0, 1);
    hi = '{0, 0};
    repeat (12) tick(0, 1);
    chk("rst_no_resume", hi[1], 0);

    // randomized press/release/mode traffic against the model
    sel_r = 1'b1;
    for (int c = 0; c < 4000; ) begin
      int len;
      bit v;
      len = $urandom_range(1, 10);
      v   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) sel_r = ~sel_r;
      repeat (len) begin
        tick(v, sel_r);
        c++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
